// File: rtl/pipe_trace_monitor_pkg.sv
// Shared defaults, the bubble encoding and the per-stage update rule for the
// pipeline trace monitor.
package pipe_trace_monitor_pkg;

    localparam int STAGES_DEF      = 5;
    localparam int IW_DEF          = 32;
    localparam int CW_DEF          = 16;
    localparam int STALL_STAGE_DEF = 1;
    localparam int FLUSH_DEPTH_DEF = 2;

    // A bubble is an all-zero instruction word with its valid flag cleared.
    localparam logic BUBBLE_VALID = 1'b0;

    typedef enum logic [1:0] {
        STG_ADVANCE = 2'd0,
        STG_HOLD    = 2'd1,
        STG_BUBBLE  = 2'd2
    } stage_op_e;

    // Flush kills the young stages first; the stall slot still gets its bubble
    // when it lies beyond the flushed region.
    function automatic stage_op_e stage_op(input int k, input int stall_stage,
                                           input int flush_depth,
                                           input logic stall, input logic flush);
        stage_op_e op;
        if (flush && (k < flush_depth)) begin
            op = STG_BUBBLE;
        end else if (stall && (k == stall_stage + 1)) begin
            op = STG_BUBBLE;
        end else if (stall && !flush && (k <= stall_stage)) begin
            op = STG_HOLD;
        end else begin
            op = STG_ADVANCE;
        end
        return op;
    endfunction

endpackage

// File: rtl/pipe_trace_counter.sv
// Saturating event counter with synchronous clear that beats a same-cycle increment.
module pipe_trace_counter
    import pipe_trace_monitor_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {CW{1'b1}})) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_trace_monitor.sv
// Shadow pipeline that tracks which instruction sits in each stage, honouring
// stalls and flushes, plus stall/flush/retire event counters.
module pipe_trace_monitor
    import pipe_trace_monitor_pkg::*;
#(
    parameter int STAGES      = STAGES_DEF,
    parameter int IW          = IW_DEF,
    parameter int CW          = CW_DEF,
    parameter int STALL_STAGE = STALL_STAGE_DEF,
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IW-1:0]        if_instr,
    input  logic                 if_valid,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 cnt_clear,
    output logic [STAGES*IW-1:0] stage_instr,
    output logic [STAGES-1:0]    stage_valid,
    output logic                 retire_valid,
    output logic [IW-1:0]        retire_instr,
    output logic [CW-1:0]        stall_cnt,
    output logic [CW-1:0]        flush_cnt,
    output logic [CW-1:0]        retire_cnt
);

    logic [IW-1:0] fetch_instr_s;
    logic          fetch_valid_s;
    logic [IW-1:0] instr_w [STAGES];
    logic          valid_w [STAGES];

    // Zero words are never real instructions, so they enter as bubbles.
    assign fetch_valid_s = if_valid && (if_instr != '0);
    assign fetch_instr_s = fetch_valid_s ? if_instr : '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [IW-1:0] instr_q;
        logic [IW-1:0] instr_d;
        logic          valid_q;
        logic          valid_d;
        logic [IW-1:0] up_instr;
        logic          up_valid;
        stage_op_e     op;

        if (k == 0) begin : g_head
            assign up_instr = fetch_instr_s;
            assign up_valid = fetch_valid_s;
        end else begin : g_body
            assign up_instr = instr_w[k-1];
            assign up_valid = valid_w[k-1];
        end

        always_comb begin
            op = stage_op(k, STALL_STAGE, FLUSH_DEPTH, stall, flush);
            case (op)
                STG_ADVANCE: begin
                    instr_d = up_instr;
                    valid_d = up_valid;
                end
                STG_HOLD: begin
                    instr_d = instr_q;
                    valid_d = valid_q;
                end
                STG_BUBBLE: begin
                    instr_d = '0;
                    valid_d = BUBBLE_VALID;
                end
                default: begin
                    instr_d = '0;
                    valid_d = BUBBLE_VALID;
                end
            endcase
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                instr_q <= '0;
                valid_q <= 1'b0;
            end else begin
                instr_q <= instr_d;
                valid_q <= valid_d;
            end
        end

        assign instr_w[k]               = instr_q;
        assign valid_w[k]               = valid_q;
        assign stage_instr[k*IW +: IW]  = instr_q;
        assign stage_valid[k]           = valid_q;
    end

    assign retire_valid = valid_w[STAGES-1];
    assign retire_instr = instr_w[STAGES-1];

    pipe_trace_counter #(.CW(CW)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (stall),
        .count (stall_cnt)
    );

    pipe_trace_counter #(.CW(CW)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (flush),
        .count (flush_cnt)
    );

    pipe_trace_counter #(.CW(CW)) u_retire_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (retire_valid),
        .count (retire_cnt)
    );

endmodule
